pipelined_adder: RTL

- Parametrised, pipelined N-bit binary adder; successor to the team's fixed 4-bit ripple adder.
- Splits the WIDTH-bit add into WIDTH/CHUNK ripple chunks, one chunk per pipeline stage, with the carry registered between stages.
- Uses a valid/ready stream handshake on both sides and sustains one result per cycle.
- Sits between arithmetic datapath stages and their consumers; also serves as the building block for the future ALU.

---
 rtl/adder_pkg.sv | 28 ++
 rtl/adder_chunk.sv | 34 +++
 rtl/pipelined_adder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and helpers for the pipelined adder family.
//   ADDER_DEFAULT_WIDTH / ADDER_DEFAULT_CHUNK : default operand and chunk widths
//   adder_stages()                            : number of pipeline stages
//   `ADDER_CHECK_CHUNKING(W, C)               : elaboration-time guard that W is a
//                                               multiple of C (use at module scope)
// No ports.

`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

`define ADDER_CHECK_CHUNKING(W, C) \
    if (((W) % (C)) != 0) begin : g_bad_chunking \
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", (W), (C)); \
    end

package adder_pkg;

    localparam int unsigned ADDER_DEFAULT_WIDTH = 16;
    localparam int unsigned ADDER_DEFAULT_CHUNK = 4;

    function automatic int unsigned adder_stages(input int unsigned width,
                                                 input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

`endif

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple-carry adder slice.
//   a, b       : chunk operands
//   carry_in   : carry into bit 0 of the chunk
//   sum        : chunk sum
//   carry_out  : carry out of the chunk MSB
//   carry_msb  : carry into the chunk MSB (used for signed overflow)

module adder_chunk
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK = ADDER_DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             carry_msb
);

    always_comb begin : ripple
        logic c;
        c         = carry_in;
        sum       = '0;
        carry_msb = 1'b0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) carry_msb = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into WIDTH/CHUNK ripple chunks, one
// chunk per pipeline stage, with valid/ready handshakes on both sides.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready = global enable)
//   a, b, carry_in        : operands and carry into bit 0
//   sub                   : (only with ADDER_SUB_EN defined) compute a - b
//   out_valid / out_ready : output handshake
//   sum, carry_out        : {carry_out, sum} = a + b + carry_in
//   overflow              : signed overflow (carry into MSB ^ carry out)
// Optional feature macro: ADDER_SUB_EN.

module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH,
    parameter int unsigned CHUNK = ADDER_DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned STAGES = adder_stages(WIDTH, CHUNK);

    `ADDER_CHECK_CHUNKING(WIDTH, CHUNK)

    logic              en;
    logic [STAGES-1:0] stage_valid;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;

`ifdef ADDER_SUB_EN
    // Subtraction is folded in at the input: a + ~b + 1 is an ordinary add of
    // a pre-inverted operand, so the mode travels implicitly with the data.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : carry_in;
`else
    assign b_eff   = b;
    assign cin_eff = carry_in;
`endif

    // Global stall: every stage advances together or holds together.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = stage_valid[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
        end else if (en) begin
            stage_valid[0] <= in_valid;
            for (int unsigned k = 1; k < STAGES; k++) begin
                stage_valid[k] <= stage_valid[k-1];
            end
        end
    end

    // Stage k consumes chunk k of the skewed operands and appends its sum
    // chunk to the completed lower chunks, so the sum register grows by one
    // chunk per stage while the operand register shrinks by one chunk.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO   = k * CHUNK;
        localparam int unsigned DONE = LO + CHUNK;

        logic [WIDTH-1:LO] a_in;
        logic [WIDTH-1:LO] b_in;
        logic              c_in;
        logic [DONE-1:0]   sum_d;
        logic [DONE-1:0]   sum_q;
        logic              carry_q;
        logic [CHUNK-1:0]  chunk_sum;
        logic              chunk_carry;
        logic              chunk_msb_carry;

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a         (a_in[LO +: CHUNK]),
            .b         (b_in[LO +: CHUNK]),
            .carry_in  (c_in),
            .sum       (chunk_sum),
            .carry_out (chunk_carry),
            .carry_msb (chunk_msb_carry)
        );

        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = cin_eff;
            assign sum_d = chunk_sum;
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_skew.a_q;
            assign b_in  = g_stage[k-1].g_skew.b_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign sum_d = {chunk_sum, g_stage[k-1].sum_q};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (en) begin
                sum_q   <= sum_d;
                carry_q <= chunk_carry;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:DONE] a_q;
            logic [WIDTH-1:DONE] b_q;
            logic                msb_carry_unused;

            assign msb_carry_unused = chunk_msb_carry;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[WIDTH-1:DONE];
                    b_q <= b_in[WIDTH-1:DONE];
                end
            end
        end else begin : g_out
            logic overflow_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    overflow_q <= 1'b0;
                end else if (en) begin
                    overflow_q <= chunk_msb_carry ^ chunk_carry;
                end
            end

            assign sum       = sum_q;
            assign carry_out = carry_q;
            assign overflow  = overflow_q;
        end
    end

endmodule
